// File: rtl/dds_burst_tx_if.sv
// Sweep-controller <-> DDS burst transmitter signal bundle.
// The master side (sweep controller / bench) drives the request and
// configuration; the slave side (dds_burst_tx) returns the DAC stream
// and status flags.
interface dds_burst_tx_if #(
  parameter int ACC_WIDTH      = 32,
  parameter int MAGNITUD_WIDTH = 14
);
  logic                             start;
  logic                             stop;
  logic        [ACC_WIDTH-1:0]      freq_word;
  logic        [15:0]               ciclos;
  logic signed [MAGNITUD_WIDTH-1:0] DAC_S;
  logic                             window;
  logic                             ref_sync;
  logic                             busy;
  logic                             fin;
  logic                             err;

  modport master (
    output start, stop, freq_word, ciclos,
    input  DAC_S, window, ref_sync, busy, fin, err
  );

  modport slave (
    input  start, stop, freq_word, ciclos,
    output DAC_S, window, ref_sync, busy, fin, err
  );
endinterface

// File: rtl/dds_burst_tx.sv
// DDS sine-burst generator for the impedance-measurement transmit path.
// A phase accumulator drives a quarter-wave ROM through a 3-register
// pipeline; window/ref_sync travel with each sample so the detector sees
// them aligned to DAC_S.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; pipeline injects zeros
//   ST_RUN   | accumulator stepping, one phase injected per cycle
//   ST_DRAIN | no injection; waiting for the last sample to leave DAC_S
module dds_burst_tx #(
  parameter int ACC_WIDTH      = 32,
  parameter int LUT_ADDR       = 8,
  parameter int MAGNITUD_WIDTH = 14,
  parameter int SETTLE_PERIODS = 2
) (
  input  logic          clk125,
  input  logic          areset_n,
  dds_burst_tx_if.slave bus
);

  localparam int  IDX_W = LUT_ADDR + 2;
  localparam int  ROM_N = 2 ** LUT_ADDR;
  localparam int  ENT_W = MAGNITUD_WIDTH - 1;
  localparam int  AMP   = 2 ** (MAGNITUD_WIDTH - 1) - 1;
  localparam int  PC_W  = 17;
  localparam real PI    = 3.14159265358979323846;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Quarter-wave entry k: sine at the bin centre, via a Taylor series so
  // the table is built at elaboration without math library calls.
  function automatic int rom_val(input int k);
    real x;
    real term;
    real s;
    x    = 2.0 * PI * (real'(k) + 0.5) / real'(2 ** (LUT_ADDR + 2));
    term = x;
    s    = x;
    for (int n = 1; n < 10; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return $rtoi(real'(AMP) * s + 0.5);
  endfunction

  state_t                   state, state_nxt;
  logic [ACC_WIDTH-1:0]     acc, fw_q;
  logic [ACC_WIDTH:0]       acc_sum;
  logic [PC_W-1:0]          pidx, plast_q;
  logic                     ph_sync;
  logic [1:0]               drain_cnt;
  logic [15:0]              cic_eff;
  logic                     wrap, last_wrap;
  logic                     accept, reject, inject, kill, drain_ld, fin_nxt;
  logic [IDX_W-1:0]         idx;

  logic [ENT_W-1:0]         rom [ROM_N];

  logic [LUT_ADDR-1:0]      s1_addr;
  logic                     s1_neg, s1_vld, s1_win, s1_sync;
  logic [ENT_W-1:0]         s2_mag;
  logic                     s2_neg, s2_win, s2_sync;
  logic [MAGNITUD_WIDTH-1:0] mag_ext;
  logic [MAGNITUD_WIDTH-1:0] dac_q;
  logic                     win_q, sync_q, fin_q, err_q;

  for (genvar k = 0; k < ROM_N; k++) begin : g_rom
    localparam int VAL = rom_val(k);
    assign rom[k] = ENT_W'(VAL);
  end

  assign acc_sum   = {1'b0, acc} + {1'b0, fw_q};
  assign wrap      = acc_sum[ACC_WIDTH];
  // The wrap that would open period SETTLE+ciclos ends the burst.
  assign last_wrap = wrap && (pidx == plast_q);
  assign cic_eff   = (bus.ciclos == 16'd0) ? 16'd1 : bus.ciclos;
  assign idx       = acc[ACC_WIDTH-1 -: IDX_W];
  assign mag_ext   = {1'b0, s2_mag};

  // State register.
  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Next-state and control strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    inject    = 1'b0;
    kill      = 1'b0;
    drain_ld  = 1'b0;
    fin_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.freq_word != '0) begin
            accept    = 1'b1;
            state_nxt = ST_RUN;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          kill      = 1'b1;
          drain_ld  = 1'b1;
          state_nxt = ST_DRAIN;
        end else begin
          inject = 1'b1;
          if (last_wrap) begin
            drain_ld  = 1'b1;
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        kill = bus.stop;
        if (drain_cnt == 2'd0) begin
          fin_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Phase accumulator, period counter and burst configuration latches.
  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      acc       <= '0;
      fw_q      <= '0;
      pidx      <= '0;
      plast_q   <= '0;
      ph_sync   <= 1'b0;
      drain_cnt <= '0;
    end else begin
      if (accept) begin
        acc     <= '0;
        fw_q    <= bus.freq_word;
        pidx    <= '0;
        ph_sync <= 1'b1;
        plast_q <= PC_W'(SETTLE_PERIODS) + PC_W'(cic_eff) - PC_W'(1);
      end else if (inject) begin
        acc     <= acc_sum[ACC_WIDTH-1:0];
        ph_sync <= wrap;
        if (wrap) pidx <= pidx + PC_W'(1);
      end
      if (drain_ld)
        drain_cnt <= 2'd2;
      else if (state == ST_DRAIN && drain_cnt != 2'd0)
        drain_cnt <= drain_cnt - 2'd1;
    end
  end

  // Stage 1: fold the phase onto the quarter-wave address and sign.
  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      s1_addr <= '0;
      s1_neg  <= 1'b0;
      s1_vld  <= 1'b0;
      s1_win  <= 1'b0;
      s1_sync <= 1'b0;
    end else if (inject) begin
      s1_addr <= idx[LUT_ADDR] ? ~idx[LUT_ADDR-1:0] : idx[LUT_ADDR-1:0];
      s1_neg  <= idx[LUT_ADDR+1];
      s1_vld  <= 1'b1;
      s1_win  <= (pidx >= PC_W'(SETTLE_PERIODS));
      s1_sync <= ph_sync;
    end else begin
      s1_addr <= '0;
      s1_neg  <= 1'b0;
      s1_vld  <= 1'b0;
      s1_win  <= 1'b0;
      s1_sync <= 1'b0;
    end
  end

  // Stage 2: ROM read; an abort clears window on samples already in flight.
  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      s2_mag  <= '0;
      s2_neg  <= 1'b0;
      s2_win  <= 1'b0;
      s2_sync <= 1'b0;
    end else begin
      s2_mag  <= s1_vld ? rom[s1_addr] : '0;
      s2_neg  <= s1_neg & s1_vld;
      s2_win  <= s1_win & ~kill;
      s2_sync <= s1_sync;
    end
  end

  // Stage 3: apply sign into the DAC output register.
  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      dac_q  <= '0;
      win_q  <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      dac_q  <= s2_neg ? (-mag_ext) : mag_ext;
      win_q  <= s2_win & ~kill;
      sync_q <= s2_sync;
    end
  end

  // One-cycle status pulses.
  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      fin_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      fin_q <= fin_nxt;
      err_q <= reject;
    end
  end

  assign bus.DAC_S    = dac_q;
  assign bus.window   = win_q;
  assign bus.ref_sync = sync_q;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.fin      = fin_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_dds_burst_tx.sv
// Bench for dds_burst_tx: table of bursts checked against a phase-level
// reference model through an expected-output queue, plus hand-written
// reset, reject and abort sequences.
module tb_dds_burst_tx;
  logic clk = 1'b0;
  logic rst_n;

  always #4 clk = ~clk;

  dds_burst_tx_if #(.ACC_WIDTH(32), .MAGNITUD_WIDTH(14)) bus ();

  dds_burst_tx #(
    .ACC_WIDTH(32), .LUT_ADDR(8), .MAGNITUD_WIDTH(14), .SETTLE_PERIODS(2)
  ) dut (
    .clk125(clk), .areset_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [31:0] fw;
    logic [15:0] cic;
    int          stop_k;
    bit          restart;
    int          exp_win;
    int          exp_sync;
    int          exp_fin;
  } vec_t;

  typedef struct {
    int dac;
    bit win;
    bit sync;
    bit busy;
    bit fin;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   obs [0:4095];
  int   o_win, o_sync, o_fin, o_max, o_min, o_mism;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int samp(input logic [31:0] p);
    int idx;
    idx = int'(p[31:22]);
    return int'(8191.0 * $sin(2.0 * 3.14159265358979323846 * (real'(idx) + 0.5) / 1024.0));
  endfunction

  function automatic exp_t mk(input int d, input bit w, input bit s, input bit b, input bit f);
    exp_t e;
    e.dac = d; e.win = w; e.sync = s; e.busy = b; e.fin = f;
    return e;
  endfunction

  // Expected output for every cycle after the start cycle, through fin.
  task automatic build_model(input vec_t v);
    logic [31:0] acc;
    logic [32:0] sum;
    int          pidx, cic, j;
    bit          sync, done, w;
    cic  = (v.cic == 16'd0) ? 1 : int'(v.cic);
    for (int i = 0; i < 3; i++) sbq.push_back(mk(0, 0, 0, 1, 0));
    acc  = '0; pidx = 0; sync = 1'b1; j = 0; done = 1'b0;
    while (!done) begin
      if (v.stop_k >= 0 && j == v.stop_k) begin
        done = 1'b1;
        sbq.push_back(mk(0, 0, 0, 1, 0));
      end else begin
        w = (pidx >= 2) && !(v.stop_k >= 0 && j >= v.stop_k - 2);
        sbq.push_back(mk(samp(acc), w, sync, 1, 0));
        sum = {1'b0, acc} + {1'b0, v.fw};
        if (sum[32] && (pidx + 1 == 2 + cic)) begin
          done = 1'b1;
        end else begin
          acc  = sum[31:0];
          sync = sum[32];
          if (sum[32]) pidx++;
        end
        j++;
      end
    end
    sbq.push_back(mk(0, 0, 0, 0, 1));
  endtask

  task automatic run_burst(input vec_t v);
    exp_t e;
    int   cyc, d;
    @(negedge clk);
    bus.start = 1'b1; bus.stop = 1'b0; bus.freq_word = v.fw; bus.ciclos = v.cic;
    sbq.delete();
    build_model(v);
    @(negedge clk);
    bus.start = 1'b0; bus.freq_word = 32'h0000_1234; bus.ciclos = 16'd7;
    o_win = 0; o_sync = 0; o_fin = -1; o_max = -99999; o_min = 99999; o_mism = 0;
    cyc = 1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      d = int'($signed(bus.DAC_S));
      if (cyc < 4096) obs[cyc] = d;
      if (bus.window === 1'b1) o_win++;
      if (bus.ref_sync === 1'b1) o_sync++;
      if (bus.fin === 1'b1 && o_fin < 0) o_fin = cyc;
      if (d > o_max) o_max = d;
      if (d < o_min) o_min = d;
      if (d != e.dac || bus.window !== e.win || bus.ref_sync !== e.sync ||
          bus.busy !== e.busy || bus.fin !== e.fin || bus.err !== 1'b0) begin
        if (o_mism == 0)
          $display("  first stream diff at cycle %0d: dac %0d/%0d win %b/%b sync %b/%b busy %b/%b fin %b/%b",
                   cyc, d, e.dac, bus.window, e.win, bus.ref_sync, e.sync,
                   bus.busy, e.busy, bus.fin, e.fin);
        o_mism++;
      end
      bus.stop  = (v.stop_k >= 0) && (cyc == v.stop_k + 1);
      bus.start = v.restart && (cyc == 500);
      if (bus.start) begin
        bus.freq_word = 32'h0100_0000; bus.ciclos = 16'd9;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0; bus.stop = 1'b0;
  endtask

  vec_t vecs [5];
  int   bad, asym, fin_at;

  initial begin
    vecs[0] = '{32'h0040_0000, 16'd1, -1,   1'b0, 1024, 3, 3076};
    vecs[1] = '{32'h0080_0000, 16'd2, -1,   1'b1, 1024, 4, 2052};
    vecs[2] = '{32'h0123_4567, 16'd3, -1,   1'b0,  675, 5, 1130};
    vecs[3] = '{32'h0080_0000, 16'd5, 1586, 1'b0,  560, 4, 1591};
    vecs[4] = '{32'h0100_0000, 16'd0, -1,   1'b0,  256, 3,  772};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.freq_word = '0; bus.ciclos = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.DAC_S, bus.window, bus.ref_sync, bus.busy, bus.fin, bus.err}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_burst(vecs[i]);
      check($sformatf("v%0d_stream_mismatches", i), o_mism, 0);
      check($sformatf("v%0d_window_cycles", i), o_win, vecs[i].exp_win);
      check($sformatf("v%0d_ref_sync_count", i), o_sync, vecs[i].exp_sync);
      check($sformatf("v%0d_fin_cycle", i), o_fin, vecs[i].exp_fin);
      check($sformatf("v%0d_idle_after", i), {bus.DAC_S, bus.busy, bus.fin, bus.window}, 0);
      if (vecs[i].fw == 32'h0040_0000 && vecs[i].cic == 16'd1) begin
        check("sample0", obs[4], 25);
        check("sample255", obs[4 + 255], 8191);
        check("sample512", obs[4 + 512], -25);
      end
      if (vecs[i].restart) begin
        asym = 0;
        for (int n = 0; n < 256; n++)
          if (obs[4 + n] != -obs[4 + n + 256]) asym++;
        check("half_period_antisymmetry", asym, 0);
        check("max_sample", o_max, 8191);
        check("min_sample", o_min, -8191);
      end
    end

    // Rejected start: freq_word of zero.
    @(negedge clk);
    bus.start = 1'b1; bus.freq_word = '0; bus.ciclos = 16'd1;
    @(negedge clk);
    bus.start = 1'b0;
    check("reject_err", bus.err, 1);
    check("reject_busy", bus.busy, 0);
    @(negedge clk);
    check("reject_err_one_cycle", bus.err, 0);

    // Stop while idle does nothing.
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    @(negedge clk);
    check("idle_stop_noop", {bus.busy, bus.fin, bus.err}, 0);

    // Start and stop together in idle: start wins; then abort early.
    bus.start = 1'b1; bus.stop = 1'b1; bus.freq_word = 32'h0040_0000; bus.ciclos = 16'd1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    check("idle_start_beats_stop", bus.busy, 1);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    fin_at = -1;
    for (int i = 0; i < 10; i++) begin
      if (bus.fin === 1'b1 && fin_at < 0) fin_at = i;
      @(negedge clk);
    end
    check("early_abort_fin_latency", fin_at, 3);

    // Asynchronous reset in the middle of the measured window.
    bus.start = 1'b1; bus.freq_word = 32'h0040_0000; bus.ciclos = 16'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2100) @(negedge clk);
    check("pre_reset_window", bus.window, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {bus.DAC_S, bus.window, bus.ref_sync, bus.busy, bus.fin}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.DAC_S != 0 || bus.busy || bus.fin || bus.window || bus.ref_sync) bad++;
    end
    check("post_reset_quiet", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dds_burst_tx.md
Name: dds_burst_tx

Overview:
- Transmit-side stimulus generator for the impedance-measurement path. It synthesises a 14-bit signed sine burst for the DAC from a 32-bit phase accumulator and a quarter-wave ROM.
- Settle periods are emitted first, then an integer number of measured periods. Window and period-sync flags are pipeline-aligned to the samples, so the magnitude/phase detector integrates exactly over whole periods.
- Sits on clk125 between the sweep controller (frequency word, start) and the DAC output register.

Parameters:
- ACC_WIDTH, 32, phase accumulator width; f_out = freq_word*125 MHz/2^ACC_WIDTH.
- LUT_ADDR, 8, quarter-wave ROM address bits (2^LUT_ADDR entries).
- MAGNITUD_WIDTH, 14, DAC sample width (signed).
- SETTLE_PERIODS, 2, unmeasured periods emitted before the window opens.

Ports:
- clk125  in  1  sole clock, 125 MHz.
- areset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; freq_word and ciclos are sampled in the same cycle.
- stop  in  1  synchronous abort.
- freq_word  in  ACC_WIDTH  phase increment.
- ciclos  in  16  measured periods; 0 is treated as 1.
- DAC_S  out  MAGNITUD_WIDTH  registered signed sample.
- window  out  1  high on samples belonging to measured periods.
- ref_sync  out  1  high on the first sample of each period (accumulator wrap or start).
- busy  out  1  high from the accepted start until fin.
- fin  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; accumulator 0; pipeline flags cleared.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start with freq_word != 0. Latch freq_word, latch ciclos (0->1), clear acc, clear period counter.
  - start with freq_word == 0: stay in IDLE, pulse err next cycle.
  - start while busy: ignored (no err).
- RUN, each cycle:
  - acc <= acc + freq_word, modulo 2^ACC_WIDTH.
  - The first RUN cycle uses phase 0 and counts as a period start.
  - Carry-out of acc marks a period start on the next phase.
  - Period counter increments at each period start.
  - A phase is in the window when its period index (0-based) lies in [SETTLE_PERIODS, SETTLE_PERIODS+ciclos-1].
  - The period start that would begin index SETTLE_PERIODS+ciclos is not emitted; FSM moves RUN -> DRAIN.
- Sample mapping, per phase p:
  - idx = top LUT_ADDR+2 bits of p; q = idx[LUT_ADDR+1:LUT_ADDR]; a = idx[LUT_ADDR-1:0].
  - ROM address = q[0] ? ~a : a.
  - ROM entry k = round((2^(MAGNITUD_WIDTH-1)-1)*sin(2π(k+0.5)/2^(LUT_ADDR+2))), unsigned. Generated at elaboration; no file dependency.
  - Sample = q[1] ? -entry : +entry, two's complement. Never reaches -2^(MAGNITUD_WIDTH-1).
- Pipeline is 3 registers: phase -> ROM address/sign -> ROM data -> DAC_S.
  - DAC_S, window and ref_sync for a phase appear 3 cycles after that phase is held in acc.
  - Non-RUN phases inject sample 0, window 0, ref_sync 0.
- DRAIN: wait 3 cycles until the last emitted sample leaves DAC_S.
  - Next cycle: fin=1 for one cycle, busy=0, return to IDLE.
  - In that cycle DAC_S=0 and window=0.
- stop:
  - In RUN or DRAIN: the accumulator stops injecting immediately and window is forced 0 on all later samples.
  - Existing pipeline samples drain; go to DRAIN, then fin pulses. Same fin timing rule applies.
  - stop in IDLE: no effect.
  - stop and start in the same cycle while busy: stop wins. In IDLE, start wins and stop is ignored.
- freq_word/ciclos changes during a burst have no effect (latched copies are used).
- Async reset mid-burst: everything returns to reset values immediately; no fin.
- Non-integer period lengths are allowed; period boundaries are defined solely by accumulator wraps.

Test Plan:
- Reset sweep: assert areset_n=0 mid-RUN -> DAC_S, window, ref_sync, busy, fin all 0 in the same cycle. After release, no output until start.
- Single step/cycle (LUT_ADDR=8, freq_word=2^22, SETTLE_PERIODS=2, ciclos=1):
  - period is 1024 cycles; DAC_S[i] = round(8191*sin(2π(i+0.5)/1024)), e.g. sample 0 = 25, sample 255 = 8191, sample 512 = -25.
  - window high for exactly samples 2048..3071.
  - ref_sync at samples 0, 1024, 2048.
  - fin pulses 4 cycles after the last RUN cycle.
- Symmetry check, freq_word=2^23: 512-cycle period; sample n = -(sample n+256) for all n; max +8191, min -8191.
- Non-integer period (freq_word=0x0123_4567, ciclos=3): window spans exactly 3 ref_sync-delimited periods. Count of window-high cycles equals the sum of those 3 period lengths.
- Rejects and ignores:
  - start with freq_word=0 -> err pulse, busy stays 0.
  - second start during a burst -> no effect on period count or timing.
- Abort: stop during window period 1 of ciclos=5 -> window drops 0 starting at the first sample of the cycle after stop. fin pulses 4 cycles later; DAC_S=0 afterwards.
